inv_mix_column_seq: RTL and testbench
=====================================

# inv_mix_column_seq

Sequential AES InvMixColumns unit: accepts one 32-bit state column over a valid/ready handshake and multiplies it by the inverse MixColumns matrix in GF(2^8), using the AES polynomial x^8+x^4+x^3+x+1. It computes one output byte per cycle with a single shared GF multiply-accumulate datapath, then holds the result for a downstream valid/ready handshake. It is the decrypt-direction counterpart of the existing factor-2/3 forward multiplier and sits in the inverse-round datapath between InvShiftRows/InvSubBytes and AddRoundKey.

## Interface
- No parameters. Width is fixed at 4 bytes per column by the AES definition.
- clk_in  input  1  clock; all logic is rising-edge.
- rst_in  input  1  reset; synchronous, active-high.
- col_valid_in  input  1  column_in is valid.
- col_ready_out  output  1  unit can accept a column.
- column_in  input  32  input column; [31:24]=s0 (row 0) … [7:0]=s3.
- res_valid_out  output  1  result_out is valid.
- res_ready_in  input  1  downstream accepts the result.
- result_out  output  32  output column, same byte order as column_in.
- busy_out  output  1  high in CALC or DONE.

## Operation
- Row r output: s'_r = 0E·s_r ⊕ 0B·s_(r+1) ⊕ 0D·s_(r+2) ⊕ 09·s_(r+3), with indices taken mod 4.
- GF multiply: xtime(b) = (b<<1) ⊕ (b[7] ? 8'h1B : 0). x2=xtime(b), x4=xtime(x2), x8=xtime(x4). Then 09=x8⊕b, 0B=x8⊕x2⊕b, 0D=x8⊕x4⊕b, 0E=x8⊕x4⊕x2. All intermediates are 8 bits; the carry is folded and never kept.
- Datapath: a 32-bit src register holds the column. Each CALC cycle applies fixed coefficients (0E,0B,0D,09) to bytes [31:24],[23:16],[15:8],[7:0], XORs the four products, and shifts the byte into res_reg from the LSB end (res_reg <= {res_reg[23:0], byte}). src then rotates left by 8.
- FSM states: IDLE, CALC, DONE.
  - IDLE: col_ready_out=1. When col_valid_in is high: src<=column_in, row<=0, go to CALC.
  - CALC: row increments each cycle (2-bit). After the row==3 cycle, go to DONE.
  - DONE: res_valid_out=1. When res_ready_in is high, go to IDLE.
- col_ready_out=1 only in IDLE. A new column is never accepted in the same cycle that a result is consumed.
- result_out is driven from res_reg. It is stable in DONE until the handshake and keeps its last value after the handshake.
- col_valid_in outside IDLE is ignored. column_in is sampled only on acceptance.

## Timing
- Reset values: state=IDLE, col_ready_out=1, res_valid_out=0, busy_out=0, result_out=32'h0, src=0, row=0.
- Acceptance edge is T0. CALC occupies the cycles ending at edges T1…T4. res_valid_out is first high in the cycle after T4, so latency is 4 cycles from accept to valid.
- With res_ready_in tied high, the unit accepts one column per 6 cycles: 4 CALC, 1 DONE, 1 IDLE.
- Backpressure: DONE persists indefinitely while res_ready_in=0, with no change to outputs.
- rst_in high in any state, including mid-CALC or DONE with a pending result: next state is IDLE, the result is discarded, and all outputs take their reset values on that edge. rst_in has priority over all handshakes.
- The row counter wraps 3→0 only through DONE/IDLE. No state is unreachable; the default case goes to IDLE.

## Structure
- Package aes_gf_pkg holds:
  - localparam AES_POLY_LO = 8'h1B
  - localparam byte constants INV_MC_C0..C3 = 8'h0E, 8'h0B, 8'h0D, 8'h09
  - the state enum typedef {IDLE, CALC, DONE}
  - a function xtime.
- Sub-module inv_gf_mult is combinational. It takes byte_in[7:0] and a 2-bit factor select (0:09, 1:0B, 2:0D, 3:0E) and returns product_out[7:0]. Four instances form the row MAC.

## Test plan
- Reset then single column 32'h8E4DA1BC: accept, then res_valid_out after exactly 4 cycles with result_out=32'hDB135345.
- Back-to-back 32'h9FDC589D then 32'hD5D5D7D6 with res_ready_in=1: results 32'hF20A225C and 32'hD4D4D4D5, with col_ready_out low from the accept edge until DONE→IDLE.
- Identity columns 32'h01010101 → 32'h01010101 and 32'hC6C6C6C6 → 32'hC6C6C6C6, which exercises all xtime reduction paths for 0xC6.
- Backpressure: res_ready_in=0 for 10 cycles in DONE. result_out and res_valid_out stay stable, and col_valid_in pulses are ignored (col_ready_out=0).
- rst_in pulsed at CALC row 2: the next cycle shows IDLE, res_valid_out=0, and result_out=0. A following column 32'h8E4DA1BC still yields 32'hDB135345.
- Random columns cross-checked against a reference model. Also checks that applying the forward MixColumns (factors 2/3) to the result recovers the original column.

Source files
------------

// File: rtl/inv_mix_column_seq_pkg.sv
// Shared GF(2^8) definitions for the AES inverse MixColumns unit:
// reduction polynomial, matrix coefficients, FSM states and xtime.
package aes_gf_pkg;

    localparam logic [7:0] AES_POLY_LO = 8'h1B;

    localparam logic [7:0] INV_MC_C0 = 8'h0E;
    localparam logic [7:0] INV_MC_C1 = 8'h0B;
    localparam logic [7:0] INV_MC_C2 = 8'h0D;
    localparam logic [7:0] INV_MC_C3 = 8'h09;

    localparam logic [1:0] FSEL_09 = 2'd0;
    localparam logic [1:0] FSEL_0B = 2'd1;
    localparam logic [1:0] FSEL_0D = 2'd2;
    localparam logic [1:0] FSEL_0E = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } inv_mc_state_e;

    // Multiply by x modulo the AES polynomial; the shifted-out bit is folded back.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY_LO : 8'h00);
    endfunction

    // Maps a matrix coefficient onto the multiplier's factor select.
    function automatic logic [1:0] coef_sel(input logic [7:0] coef);
        case (coef)
            INV_MC_C3: return FSEL_09;
            INV_MC_C1: return FSEL_0B;
            INV_MC_C2: return FSEL_0D;
            default:   return FSEL_0E;
        endcase
    endfunction

endpackage

// File: rtl/inv_mix_column_seq_if.sv
// Column-in / result-out handshake bundle for inv_mix_column_seq.
interface inv_mix_column_seq_if;

    logic        col_valid_in;
    logic        col_ready_out;
    logic [31:0] column_in;
    logic        res_valid_out;
    logic        res_ready_in;
    logic [31:0] result_out;
    logic        busy_out;

    modport slave (
        input  col_valid_in,
        input  column_in,
        input  res_ready_in,
        output col_ready_out,
        output res_valid_out,
        output result_out,
        output busy_out
    );

    modport master (
        output col_valid_in,
        output column_in,
        output res_ready_in,
        input  col_ready_out,
        input  res_valid_out,
        input  result_out,
        input  busy_out
    );

endinterface

// File: rtl/inv_mix_column_seq_gf_mult.sv
// Combinational GF(2^8) multiply of one byte by 09, 0B, 0D or 0E,
// built from an xtime chain so no general multiplier is needed.
module inv_gf_mult
    import aes_gf_pkg::*;
(
    input  logic [7:0] byte_in,
    input  logic [1:0] factor_sel,
    output logic [7:0] product_out
);

    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;

    assign x2 = xtime(byte_in);
    assign x4 = xtime(x2);
    assign x8 = xtime(x4);

    always_comb begin
        product_out = x8 ^ x4 ^ x2;
        case (factor_sel)
            FSEL_09: product_out = x8 ^ byte_in;
            FSEL_0B: product_out = x8 ^ x2 ^ byte_in;
            FSEL_0D: product_out = x8 ^ x4 ^ byte_in;
            default: product_out = x8 ^ x4 ^ x2;
        endcase
    end

endmodule

// File: rtl/inv_mix_column_seq.sv
// Sequential AES InvMixColumns: one output byte per cycle from a shared
// four-multiplier row MAC, result held until the downstream handshake.
module inv_mix_column_seq
    import aes_gf_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    inv_mix_column_seq_if.slave bus
);

    localparam logic [1:0] SEL_B0 = coef_sel(INV_MC_C0);
    localparam logic [1:0] SEL_B1 = coef_sel(INV_MC_C1);
    localparam logic [1:0] SEL_B2 = coef_sel(INV_MC_C2);
    localparam logic [1:0] SEL_B3 = coef_sel(INV_MC_C3);

    inv_mc_state_e state_q;
    inv_mc_state_e state_d;

    logic [31:0] src_q;
    logic [31:0] res_q;
    logic [1:0]  row_q;

    logic        accept;
    logic        calc_en;
    logic        col_ready;
    logic        res_valid;
    logic        busy;

    logic [7:0]  prod0;
    logic [7:0]  prod1;
    logic [7:0]  prod2;
    logic [7:0]  prod3;
    logic [7:0]  mac_byte;

    // The rotated src always presents s_r in the top byte, so the
    // coefficients stay fixed per byte lane.
    inv_gf_mult u_mult0 (.byte_in(src_q[31:24]), .factor_sel(SEL_B0), .product_out(prod0));
    inv_gf_mult u_mult1 (.byte_in(src_q[23:16]), .factor_sel(SEL_B1), .product_out(prod1));
    inv_gf_mult u_mult2 (.byte_in(src_q[15:8]),  .factor_sel(SEL_B2), .product_out(prod2));
    inv_gf_mult u_mult3 (.byte_in(src_q[7:0]),   .factor_sel(SEL_B3), .product_out(prod3));

    assign mac_byte = prod0 ^ prod1 ^ prod2 ^ prod3;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        calc_en   = 1'b0;
        col_ready = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                col_ready = 1'b1;
                if (bus.col_valid_in) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                busy    = 1'b1;
                calc_en = 1'b1;
                if (row_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (bus.res_ready_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Row holds at 3 on the last CALC cycle and is only cleared on acceptance.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            src_q <= 32'h0;
            res_q <= 32'h0;
            row_q <= 2'd0;
        end else if (accept) begin
            src_q <= bus.column_in;
            row_q <= 2'd0;
        end else if (calc_en) begin
            res_q <= {res_q[23:0], mac_byte};
            src_q <= {src_q[23:0], src_q[31:24]};
            if (row_q != 2'd3) begin
                row_q <= row_q + 2'd1;
            end
        end
    end

    assign bus.col_ready_out = col_ready;
    assign bus.res_valid_out = res_valid;
    assign bus.busy_out      = busy;
    assign bus.result_out    = res_q;

endmodule

// File: tb/tb_inv_mix_column_seq.sv
// Self-checking bench for inv_mix_column_seq: directed vectors plus random
// columns compared against a generic GF(2^8) matrix model.
module tb_inv_mix_column_seq;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;

    always #5 clk_in = ~clk_in;

    inv_mix_column_seq_if bus ();

    inv_mix_column_seq dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    int          pass_count  = 0;
    int          total_count = 0;
    logic [31:0] exp_result  = 32'h0;
    bit          exp_armed   = 1'b0;

    // Shift-and-add GF(2^8) product, independent of any xtime chain.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] acc;
        acc = 16'h0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ (16'(a) << i);
        end
        for (int i = 15; i >= 8; i--) begin
            if (acc[i]) acc = acc ^ (16'h011B << (i - 8));
        end
        return acc[7:0];
    endfunction

    function automatic logic [31:0] mat_mul(input logic [31:0] col, input logic [7:0] c0,
                                            input logic [7:0] c1, input logic [7:0] c2,
                                            input logic [7:0] c3);
        logic [7:0]  s [4];
        logic [7:0]  k [4];
        logic [31:0] out;
        s[0] = col[31:24]; s[1] = col[23:16]; s[2] = col[15:8]; s[3] = col[7:0];
        k[0] = c0; k[1] = c1; k[2] = c2; k[3] = c3;
        out = 32'h0;
        for (int r = 0; r < 4; r++) begin
            logic [7:0] acc;
            acc = 8'h0;
            for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(k[j], s[(r + j) % 4]);
            out = {out[23:0], acc};
        end
        return out;
    endfunction

    function automatic logic [31:0] ref_inv(input logic [31:0] col);
        return mat_mul(col, 8'h0E, 8'h0B, 8'h0D, 8'h09);
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [31:0] col);
        return mat_mul(col, 8'h02, 8'h03, 8'h01, 8'h01);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    endtask

    // Every cycle out of reset: ready and busy are complementary, and any
    // presented result must match the model for the last accepted column.
    always @(negedge clk_in) begin
        if (rst_in !== 1'b1) begin
            checkOutput("ready_vs_busy", {31'b0, bus.col_ready_out}, {31'b0, ~bus.busy_out});
            if (bus.res_valid_out === 1'b1 && exp_armed) begin
                checkOutput("stream_result", bus.result_out, exp_result);
            end
        end
    end

    task automatic waitReady();
        int n;
        n = 0;
        while (bus.col_ready_out !== 1'b1 && n < 30) begin
            @(posedge clk_in); #1;
            n++;
        end
        checkOutput("ready_timeout", {31'b0, bus.col_ready_out}, 32'd1);
    endtask

    task automatic waitValid(output int lat);
        lat = 0;
        while (bus.res_valid_out !== 1'b1 && lat < 20) begin
            @(posedge clk_in); #1;
            lat++;
            bus.column_in = $urandom;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] col, input int stall,
                                 output logic [31:0] got);
        int lat;
        waitReady();
        bus.column_in    = col;
        bus.col_valid_in = 1'b1;
        @(posedge clk_in); #1;
        bus.col_valid_in = 1'b0;
        bus.column_in    = $urandom;
        exp_result       = ref_inv(col);
        exp_armed        = 1'b1;
        checkOutput("ready_low_after_accept", {31'b0, bus.col_ready_out}, 32'd0);
        waitValid(lat);
        checkOutput("latency", lat, 32'd4);
        got = bus.result_out;
        for (int i = 0; i < stall; i++) begin
            bus.col_valid_in = 1'b1;
            bus.column_in    = $urandom;
            @(posedge clk_in); #1;
            checkOutput("stall_valid", {31'b0, bus.res_valid_out}, 32'd1);
            checkOutput("stall_hold", bus.result_out, got);
            checkOutput("stall_ready", {31'b0, bus.col_ready_out}, 32'd0);
        end
        bus.col_valid_in = 1'b0;
        bus.res_ready_in = 1'b1;
        @(posedge clk_in); #1;
        bus.res_ready_in = 1'b0;
        checkOutput("post_hs_valid", {31'b0, bus.res_valid_out}, 32'd0);
        checkOutput("post_hs_ready", {31'b0, bus.col_ready_out}, 32'd1);
        checkOutput("post_hs_hold", bus.result_out, got);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ready"}, {31'b0, bus.col_ready_out}, 32'd1);
        checkOutput({tag, "_valid"}, {31'b0, bus.res_valid_out}, 32'd0);
        checkOutput({tag, "_busy"}, {31'b0, bus.busy_out}, 32'd0);
        checkOutput({tag, "_result"}, bus.result_out, 32'h0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] col;
        int          lat;
        int          ready_seen;

        bus.col_valid_in = 1'b0;
        bus.column_in    = 32'h0;
        bus.res_ready_in = 1'b0;
        rst_in           = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        checkResetOutputs("reset");
        rst_in = 1'b0;

        $display("[TB] single column");
        applyStimulus(32'h8E4DA1BC, 0, got);
        checkOutput("single_literal", got, 32'hDB135345);

        $display("[TB] back-to-back with res_ready_in tied high");
        waitReady();
        bus.res_ready_in = 1'b1;
        bus.column_in    = 32'h9FDC589D;
        bus.col_valid_in = 1'b1;
        @(posedge clk_in); #1;
        exp_result    = ref_inv(32'h9FDC589D);
        exp_armed     = 1'b1;
        bus.column_in = 32'hD5D5D7D6;
        ready_seen    = 0;
        lat           = 0;
        while (bus.res_valid_out !== 1'b1 && lat < 20) begin
            if (bus.col_ready_out === 1'b1) ready_seen++;
            @(posedge clk_in); #1;
            lat++;
        end
        checkOutput("b2b_a_latency", lat, 32'd4);
        checkOutput("b2b_a_ready_calc", ready_seen, 32'd0);
        checkOutput("b2b_a_ready_done", {31'b0, bus.col_ready_out}, 32'd0);
        checkOutput("b2b_a_literal", bus.result_out, 32'hF20A225C);
        @(posedge clk_in); #1;
        checkOutput("b2b_idle_ready", {31'b0, bus.col_ready_out}, 32'd1);
        checkOutput("b2b_idle_valid", {31'b0, bus.res_valid_out}, 32'd0);
        @(posedge clk_in); #1;
        exp_result       = ref_inv(32'hD5D5D7D6);
        bus.col_valid_in = 1'b0;
        checkOutput("b2b_b_accepted", {31'b0, bus.busy_out}, 32'd1);
        waitValid(lat);
        checkOutput("b2b_b_latency", lat, 32'd4);
        checkOutput("b2b_b_literal", bus.result_out, 32'hD4D4D4D5);
        @(posedge clk_in); #1;
        bus.res_ready_in = 1'b0;
        checkOutput("b2b_end_ready", {31'b0, bus.col_ready_out}, 32'd1);

        $display("[TB] identity columns");
        applyStimulus(32'h01010101, 0, got);
        checkOutput("ident_01", got, 32'h01010101);
        applyStimulus(32'hC6C6C6C6, 1, got);
        checkOutput("ident_c6", got, 32'hC6C6C6C6);

        $display("[TB] backpressure");
        applyStimulus(32'h9FDC589D, 10, got);
        checkOutput("bp_literal", got, 32'hF20A225C);

        $display("[TB] reset during CALC");
        waitReady();
        bus.column_in    = 32'h8E4DA1BC;
        bus.col_valid_in = 1'b1;
        @(posedge clk_in); #1;
        bus.col_valid_in = 1'b0;
        exp_armed        = 1'b0;
        repeat (2) begin
            @(posedge clk_in); #1;
        end
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        checkResetOutputs("midcalc_reset");
        rst_in = 1'b0;
        applyStimulus(32'h8E4DA1BC, 0, got);
        checkOutput("post_reset_literal", got, 32'hDB135345);

        $display("[TB] random columns");
        for (int n = 0; n < 40; n++) begin
            col = $urandom;
            applyStimulus(col, int'($urandom_range(0, 3)), got);
            checkOutput("random_inv", got, ref_inv(col));
            checkOutput("random_roundtrip", ref_fwd(got), col);
        end

        repeat (2) @(posedge clk_in);
        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
